// File: rtl/syzygy_adc_tx_emu.sv
// Fabric-side emulator of a 2-lane, 16-bit-per-channel serial ADC output (LTC2264/LTC2268 style).
// Produces per-lane bits and the frame signal one bit time per clk; ODDR/OSERDES and DCO live outside.
module syzygy_adc_tx_emu #(
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter logic [15:0] TEST_WORD = 16'h5A3C
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] din_1,
  input  logic [15:0] din_2,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [1:0]  adc_out_1,
  output logic [1:0]  adc_out_2,
  output logic        frame_out,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_DATA  = 2'd0;
  localparam logic [1:0] MODE_TEST  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  state_t             state_q, state_d;
  logic        [2:0]  cnt_q, cnt_d;
  logic               rst_n_q;
  logic               hold_full_q, hold_full_d;
  logic        [15:0] hold1_q, hold1_d;
  logic        [15:0] hold2_q, hold2_d;
  logic        [15:0] sr1_q, sr1_d;
  logic        [15:0] sr2_q, sr2_d;
  logic        [1:0]  out1_q, out1_d;
  logic        [1:0]  out2_q, out2_d;
  logic               frame_q, frame_d;
  logic               underrun_q, underrun_d;
  logic        [15:0] underrun_count_q, underrun_count_d;
  logic        [15:0] ramp_q, ramp_d;
  logic               phase_q, phase_d;

  logic               load;
  logic               accept;
  logic               consume;
  logic               starve;
  logic        [15:0] word1;
  logic        [15:0] word2;

  // Frame sequencing: decides the next state and whether this edge loads a new frame.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == 3'd7) load = 1'b1;
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == 3'd7) begin
          if (enable) begin
            state_d = S_RUN;
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (enable) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign din_ready = rst_n_q & (~hold_full_q | load) & (mode == MODE_DATA);
  assign accept    = din_valid & din_ready;

  // Word selection for the next frame; only takes effect on a load edge.
  always_comb begin
    word1   = IDLE_WORD;
    word2   = IDLE_WORD;
    consume = 1'b0;
    starve  = 1'b0;
    case (mode)
      MODE_DATA: begin
        if (hold_full_q) begin
          word1   = hold1_q;
          word2   = hold2_q;
          consume = 1'b1;
        end else begin
          starve  = 1'b1;
        end
      end
      MODE_TEST: begin
        word1 = TEST_WORD;
        word2 = TEST_WORD;
      end
      MODE_RAMP: begin
        word1 = ramp_q;
        word2 = ~ramp_q;
      end
      MODE_CHECK: begin
        word1 = phase_q ? 16'h5555 : 16'hAAAA;
        word2 = phase_q ? 16'hAAAA : 16'h5555;
      end
      default: begin
        word1 = IDLE_WORD;
        word2 = IDLE_WORD;
      end
    endcase
  end

  // Next-state for hold register, shifters, output lanes and counters.
  always_comb begin
    hold1_d          = hold1_q;
    hold2_d          = hold2_q;
    hold_full_d      = hold_full_q;
    sr1_d            = sr1_q;
    sr2_d            = sr2_q;
    out1_d           = 2'b00;
    out2_d           = 2'b00;
    frame_d          = 1'b0;
    cnt_d            = 3'd0;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    ramp_d           = ramp_q;
    phase_d          = phase_q;

    // The old hold contents leave on a load before a same-edge accept refills it.
    if (load && consume) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold1_d     = din_1;
      hold2_d     = din_2;
    end

    if (load) begin
      out1_d  = word1[15:14];
      out2_d  = word2[15:14];
      sr1_d   = {word1[13:0], 2'b00};
      sr2_d   = {word2[13:0], 2'b00};
      cnt_d   = 3'd0;
      frame_d = 1'b1;
      if (starve) begin
        underrun_d = 1'b1;
        if (underrun_count_q != 16'hFFFF) underrun_count_d = underrun_count_q + 16'd1;
      end
      if (mode == MODE_RAMP)  ramp_d  = ramp_q + 16'd1;
      if (mode == MODE_CHECK) phase_d = ~phase_q;
    end else if (state_q != S_IDLE && cnt_q != 3'd7) begin
      out1_d  = sr1_q[15:14];
      out2_d  = sr2_q[15:14];
      sr1_d   = {sr1_q[13:0], 2'b00};
      sr2_d   = {sr2_q[13:0], 2'b00};
      cnt_d   = cnt_q + 3'd1;
      frame_d = (cnt_q < 3'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= 3'd0;
      rst_n_q          <= 1'b0;
      hold_full_q      <= 1'b0;
      out1_q           <= 2'b00;
      out2_q           <= 2'b00;
      frame_q          <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= 16'd0;
      ramp_q           <= 16'd0;
      phase_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rst_n_q          <= 1'b1;
      hold_full_q      <= hold_full_d;
      out1_q           <= out1_d;
      out2_q           <= out2_d;
      frame_q          <= frame_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      ramp_q           <= ramp_d;
      phase_q          <= phase_d;
    end
  end

  // Sample and shift data carry no reset; their validity is tracked by the control flops.
  always_ff @(posedge clk) begin
    hold1_q <= hold1_d;
    hold2_q <= hold2_d;
    sr1_q   <= sr1_d;
    sr2_q   <= sr2_d;
  end

  assign adc_out_1      = out1_q;
  assign adc_out_2      = out2_q;
  assign frame_out      = frame_q;
  assign busy           = (state_q != S_IDLE);
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_syzygy_adc_tx_emu.sv
// Scoreboard bench for syzygy_adc_tx_emu: expected frame words are queued as stimulus is
// driven and compared against words deserialised from the lanes.
module tb_syzygy_adc_tx_emu;

  localparam logic [15:0] IDLE_W = 16'h0000;
  localparam logic [15:0] TEST_W = 16'h5A3C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] din_1;
  logic [15:0] din_2;
  logic        din_valid;
  logic        din_ready;
  logic [1:0]  adc_out_1;
  logic [1:0]  adc_out_2;
  logic        frame_out;
  logic        busy;
  logic        underrun;
  logic [15:0] underrun_count;

  always #5 clk = ~clk;

  syzygy_adc_tx_emu dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .mode           (mode),
    .din_1          (din_1),
    .din_2          (din_2),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .adc_out_1      (adc_out_1),
    .adc_out_2      (adc_out_2),
    .frame_out      (frame_out),
    .busy           (busy),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  typedef struct packed {
    logic [15:0] w1;
    logic [15:0] w2;
  } frame_t;

  frame_t      exp_q[$];
  int          ur_q[$];
  int          start_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;

  logic        mon_act = 1'b0;
  int          mon_idx = 0;
  logic [15:0] mon_w1;
  logic [15:0] mon_w2;
  logic [7:0]  mon_fr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  always @(posedge clk) cyc++;

  // Deserialiser: rebuilds both channel words and the frame pattern of every full frame.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_act = 1'b0;
    end else begin
      if (underrun) ur_q.push_back(cyc);
      if (!mon_act && frame_out) begin
        mon_act = 1'b1;
        mon_idx = 0;
        mon_w1  = 16'h0;
        mon_w2  = 16'h0;
        mon_fr  = 8'h0;
        start_q.push_back(cyc);
      end
      if (mon_act) begin
        mon_w1 = {mon_w1[13:0], adc_out_1};
        mon_w2 = {mon_w2[13:0], adc_out_2};
        mon_fr = {mon_fr[6:0], frame_out};
        mon_idx++;
        if (mon_idx == 8) begin
          frame_t e;
          mon_act = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("frame_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("ch1_word", mon_w1, e.w1);
            check_eq("ch2_word", mon_w2, e.w2);
            check_eq("frame_pat", mon_fr, 8'hF0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
    frame_t f;
    f.w1 = a;
    f.w2 = b;
    exp_q.push_back(f);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    din_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_reached", (k < 300), 1);
    @(negedge clk);
    check_eq("lanes_idle", {adc_out_1, adc_out_2, frame_out}, 5'd0);
    tick();
  endtask

  // Called just after an edge: enable now, drop it during the first bit time of the last frame.
  task automatic run_frames(input int n);
    enable = 1'b1;
    repeat (8 * (n - 1) + 1) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     k;
    int     rdy_cnt;
    int     n_acc;
    logic   fire;
    logic [15:0] s1;

    reset_n   = 1'b0;
    enable    = 1'b0;
    mode      = 2'd0;
    din_1     = 16'h0;
    din_2     = 16'h0;
    din_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {adc_out_1, adc_out_2, frame_out, busy, underrun}, 7'd0);
    check_eq("rst_ready", din_ready, 1'b0);
    check_eq("rst_count", underrun_count, 16'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_after_rst", din_ready, 1'b1);
    tick();

    // Single held pair
    din_1     = 16'hA5F0;
    din_2     = 16'h0FFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    check_eq("ready_hold_full", din_ready, 1'b0);
    tick();
    push_exp(16'hA5F0, 16'h0FFF);
    run_frames(1);
    check_eq("t1_ur_count", underrun_count, 16'd0);

    // Underruns and saturation
    do_reset();
    ur_q.delete();
    repeat (3) push_exp(IDLE_W, IDLE_W);
    run_frames(3);
    check_eq("ur_pulses", ur_q.size(), 3);
    if (ur_q.size() == 3) begin
      check_eq("ur_gap1", ur_q[1] - ur_q[0], 8);
      check_eq("ur_gap2", ur_q[2] - ur_q[1], 8);
    end
    check_eq("ur_count3", underrun_count, 16'd3);
    @(negedge clk);
    force dut.underrun_count_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.underrun_count_q;
    check_eq("ur_forced", underrun_count, 16'hFFFE);
    ur_q.delete();
    repeat (3) push_exp(IDLE_W, IDLE_W);
    run_frames(3);
    check_eq("ur_pulses_sat", ur_q.size(), 3);
    check_eq("ur_count_sat", underrun_count, 16'hFFFF);

    // Back-to-back stream with accept on load edges
    do_reset();
    mode      = 2'd0;
    n_acc     = 0;
    rdy_cnt   = 0;
    s1        = 16'hC000;
    din_1     = s1;
    din_2     = ~s1;
    din_valid = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      fire = din_valid & din_ready;
      if (c >= 2 && c <= 25 && din_ready) rdy_cnt++;
      @(posedge clk);
      #1;
      if (fire) begin
        push_exp(din_1, din_2);
        n_acc++;
        s1    = s1 + 16'h0137;
        din_1 = s1;
        din_2 = ~s1;
      end
      if (c == 0)  enable = 1'b1;
      if (c == 25) enable = 1'b0;
    end
    din_valid = 1'b0;
    check_eq("b2b_ready_1_in_8", rdy_cnt, 3);
    check_eq("b2b_accepted", n_acc, 5);
    run_frames(1);
    check_eq("b2b_no_underrun", underrun_count, 16'd0);

    // Ramp, checkerboard and test word modes
    do_reset();
    mode = 2'd2;
    push_exp(16'h0000, 16'hFFFF);
    push_exp(16'h0001, 16'hFFFE);
    push_exp(16'h0002, 16'hFFFD);
    push_exp(16'h0003, 16'hFFFC);
    @(negedge clk);
    check_eq("ready_mode2", din_ready, 1'b0);
    tick();
    run_frames(4);
    mode = 2'd3;
    push_exp(16'hAAAA, 16'h5555);
    push_exp(16'h5555, 16'hAAAA);
    push_exp(16'hAAAA, 16'h5555);
    run_frames(3);
    mode = 2'd1;
    push_exp(TEST_W, TEST_W);
    push_exp(TEST_W, TEST_W);
    run_frames(2);
    check_eq("modes_no_underrun", underrun_count, 16'd0);

    // Enable dropped at bit time 2, then re-enabled at bit time 6
    push_exp(TEST_W, TEST_W);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_len", k, 7);
    wait_idle();
    start_q.delete();
    push_exp(TEST_W, TEST_W);
    push_exp(TEST_W, TEST_W);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    wait_idle();
    check_eq("reenable_frames", start_q.size(), 2);
    if (start_q.size() == 2) check_eq("reenable_gap", start_q[1] - start_q[0], 8);

    // Reset mid-frame at bit time 4, then restart
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    mode    = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_outs", {adc_out_1, adc_out_2, frame_out, busy, underrun}, 7'd0);
    check_eq("midrst_ready", din_ready, 1'b0);
    @(posedge clk);
    #1;
    push_exp(TEST_W, TEST_W);
    reset_n = 1'b1;
    mode    = 2'd1;
    @(posedge clk);
    #1 enable = 1'b0;
    wait_idle();
    check_eq("midrst_count", underrun_count, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
